// File: rtl/score_round_ctrl_if.sv
// Session control and status bundle for score_round_ctrl.
// The master side drives start/hit and session parameters; the slave side reports status and score.
interface score_round_ctrl_if;
    logic       i_start;
    logic [9:0] i_range;
    logic [3:0] i_rounds;
    logic       i_hit;
    logic       o_busy;
    logic       o_window;
    logic [3:0] o_round;
    logic [7:0] o_score;
    logic       o_done;

    modport master (
        output i_start, i_range, i_rounds, i_hit,
        input  o_busy, o_window, o_round, o_score, o_done
    );

    modport slave (
        input  i_start, i_range, i_rounds, i_hit,
        output o_busy, o_window, o_round, o_score, o_done
    );
endinterface

// File: rtl/score_round_ctrl.sv
// Timed reaction-game controller: each round counts up from 0, and the first hit is scored
// by how close the count is to the latched target. Rounds are separated by a fixed idle gap.
module score_round_ctrl #(
    parameter int WINDOW  = 2,
    parameter int GAP_CYC = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    score_round_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_RUN  = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [10:0] WIN_EXT  = 11'(WINDOW);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [9:0]  range_q, range_d;
    logic [3:0]  rounds_q, rounds_d;
    logic [3:0]  round_idx_q, round_idx_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        taken_q, taken_d;
    logic [7:0]  score_q, score_d;

    logic [10:0] range_ext;
    logic [10:0] lo_diff;
    logic [10:0] hi_sum;
    logic [9:0]  win_lo;
    logic [9:0]  win_hi;
    logic        in_win;
    logic        at_hi;
    logic        gap_end;
    logic        last_round;

    logic        busy;
    logic        window;
    logic        done;

    function automatic logic [1:0] hit_points(input logic [9:0] c, input logic [9:0] tgt,
                                              input logic [9:0] lo, input logic [9:0] hi);
        if (c == tgt)
            return 2'd2;
        else if (c >= lo && c <= hi)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    // Window bounds are clamped in 11 bits so neither edge wraps around the 10-bit count.
    always_comb begin
        range_ext = {1'b0, range_q};
        lo_diff   = range_ext - WIN_EXT;
        hi_sum    = range_ext + WIN_EXT;
        win_lo    = (range_ext >= WIN_EXT) ? lo_diff[9:0] : 10'd0;
        win_hi    = (hi_sum > 11'd1023) ? 10'd1023 : hi_sum[9:0];
    end

    assign in_win     = (cnt_q >= win_lo) && (cnt_q <= win_hi);
    assign at_hi      = (cnt_q == win_hi);
    assign gap_end    = (gap_cnt_q == GAP_LAST);
    assign last_round = ({1'b0, round_idx_q} + 5'd1) == {1'b0, rounds_q};

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start)
                    state_d = (bus.i_rounds == 4'd0) ? S_DONE : S_ARM;
            end
            S_ARM:  state_d = S_RUN;
            S_RUN: begin
                if (at_hi)
                    state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_end)
                    state_d = last_round ? S_DONE : S_ARM;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        range_d     = range_q;
        rounds_d    = rounds_q;
        round_idx_d = round_idx_q;
        gap_cnt_d   = gap_cnt_q;
        taken_d     = taken_q;
        score_d     = score_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    range_d     = bus.i_range;
                    rounds_d    = bus.i_rounds;
                    round_idx_d = 4'd0;
                    score_d     = 8'd0;
                end
            end
            S_ARM: begin
                cnt_d   = 10'd0;
                taken_d = 1'b0;
            end
            S_RUN: begin
                gap_cnt_d = 8'd0;
                // Holding at hi keeps a target of 1023 from wrapping the count to 0.
                if (!at_hi)
                    cnt_d = cnt_q + 10'd1;
                if (bus.i_hit && !taken_q) begin
                    taken_d = 1'b1;
                    score_d = score_q + {6'd0, hit_points(cnt_q, range_q, win_lo, win_hi)};
                end
            end
            S_GAP: begin
                if (gap_end)
                    round_idx_d = round_idx_q + 4'd1;
                else
                    gap_cnt_d = gap_cnt_q + 8'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q       <= 10'd0;
            range_q     <= 10'd0;
            rounds_q    <= 4'd0;
            round_idx_q <= 4'd0;
            gap_cnt_q   <= 8'd0;
            taken_q     <= 1'b0;
            score_q     <= 8'd0;
        end else begin
            cnt_q       <= cnt_d;
            range_q     <= range_d;
            rounds_q    <= rounds_d;
            round_idx_q <= round_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            taken_q     <= taken_d;
            score_q     <= score_d;
        end
    end

    always_comb begin
        busy   = (state_q != S_IDLE);
        window = (state_q == S_RUN) && in_win;
        done   = (state_q == S_DONE);
    end

    assign bus.o_busy   = busy;
    assign bus.o_window = window;
    assign bus.o_done   = done;
    assign bus.o_round  = round_idx_q;
    assign bus.o_score  = score_q;

endmodule

// File: tb/tb_score_round_ctrl.sv
// Randomized session bench for score_round_ctrl; expected outputs come from a timeline model
// derived from target, window, gap length and round count.
module tb_score_round_ctrl;

    localparam int WINDOW  = 2;
    localparam int GAP_CYC = 4;

    logic clk;
    logic rst;
    score_round_ctrl_if bus();

    score_round_ctrl #(
        .WINDOW (WINDOW),
        .GAP_CYC(GAP_CYC)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    int n_checks  = 0;
    int n_fail    = 0;
    int exp_score = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx, input int busy, input int win, input int done,
                                 input int round, input bit chk_round);
        chk($sformatf("%s busy", ctx), int'(bus.o_busy), busy);
        chk($sformatf("%s window", ctx), int'(bus.o_window), win);
        chk($sformatf("%s done", ctx), int'(bus.o_done), done);
        chk($sformatf("%s score", ctx), int'(bus.o_score), exp_score);
        if (chk_round)
            chk($sformatf("%s round", ctx), int'(bus.o_round), round);
    endtask

    // One session starting in the cycle of the first negedge. hit0 >= 0 forces the round-0 hit
    // count; noisy adds random hits; abort_k >= 0 resets the DUT in round 1 at that count.
    task automatic run_session(input int rng, input int nr, input int hit0, input bit noisy,
                               input int abort_k);
        int  lo, hi, len, end_rel, abort_rel;
        int  j, p, k, e_busy, e_win, e_done;
        bit  in_run, chk_r, hit;
        bit  taken[16];
        int  plan_a[16];
        int  plan_b[16];
        string ctx;

        lo = rng - WINDOW;
        if (lo < 0) lo = 0;
        hi = rng + WINDOW;
        if (hi > 1023) hi = 1023;
        len     = 1 + (hi + 1) + GAP_CYC;
        end_rel = (nr == 0) ? 2 : nr * len + 2;
        abort_rel = (abort_k >= 0) ? (1 + len + 1 + abort_k) : -1;

        for (int r = 0; r < 16; r++) begin
            taken[r]  = 1'b0;
            plan_a[r] = noisy ? rng + int'($urandom_range(0, 6)) - 3 : -1;
            plan_b[r] = noisy ? int'($urandom_range(0, hi)) : -1;
        end
        if (hit0 >= 0) plan_a[0] = hit0;

        for (int rel = 0; rel <= end_rel; rel++) begin
            @(negedge clk);
            in_run = 1'b0; chk_r = 1'b0; k = 0; j = 0;
            e_busy = 0; e_done = 0;
            if (rel == 0 || rel == end_rel) begin
                e_busy = 0;
            end else if (rel == end_rel - 1) begin
                e_busy = 1; e_done = 1;
            end else begin
                e_busy = 1; chk_r = 1'b1;
                j = (rel - 1) / len;
                p = (rel - 1) % len;
                if (p >= 1 && p <= hi + 1) begin
                    in_run = 1'b1;
                    k = p - 1;
                end
            end
            e_win = (in_run && k >= lo && k <= hi) ? 1 : 0;
            ctx = $sformatf("r%0d/n%0d rel%0d", rng, nr, rel);
            check_outputs(ctx, e_busy, e_win, e_done, j, chk_r);

            if (rel == abort_rel) begin
                rst          = 1'b1;
                bus.i_start  = 1'b1;
                bus.i_hit    = 1'b1;
                bus.i_range  = 10'($urandom);
                bus.i_rounds = 4'd3;
                @(negedge clk);
                exp_score = 0;
                check_outputs("after abort", 0, 0, 0, 0, 1'b1);
                rst         = 1'b0;
                bus.i_start = 1'b0;
                bus.i_hit   = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_outputs("idle after abort", 0, 0, 0, 0, 1'b1);
                end
                return;
            end

            if (rel == 0) begin
                bus.i_start  = 1'b1;
                bus.i_range  = 10'(rng);
                bus.i_rounds = 4'(nr);
                exp_score    = 0;
            end else if (rel < end_rel) begin
                bus.i_start  = ($urandom_range(0, 7) == 0);
                bus.i_range  = 10'($urandom);
                bus.i_rounds = 4'($urandom);
            end else begin
                bus.i_start = 1'b0;
            end

            if (in_run)
                hit = (k == plan_a[j]) || (k == plan_b[j]) || (noisy && $urandom_range(0, 31) == 0);
            else
                hit = noisy && ($urandom_range(0, 3) == 0);
            bus.i_hit = hit;

            if (in_run && hit && !taken[j]) begin
                taken[j] = 1'b1;
                if (k == rng)
                    exp_score += 2;
                else if (k >= lo && k <= hi)
                    exp_score += 1;
            end
        end
        bus.i_hit = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.i_start  = 1'b1;
        bus.i_hit    = 1'b1;
        bus.i_range  = 10'd5;
        bus.i_rounds = 4'd1;
        repeat (3) @(negedge clk);
        exp_score = 0;
        check_outputs("reset", 0, 0, 0, 0, 1'b1);
        rst         = 1'b0;
        bus.i_start = 1'b0;
        bus.i_hit   = 1'b0;
        @(negedge clk);
        check_outputs("idle", 0, 0, 0, 0, 1'b1);

        run_session(5,    1,  5,    1'b0, -1);
        run_session(1,    1,  0,    1'b0, -1);
        run_session(1023, 1,  1021, 1'b0, -1);
        run_session(0,    2,  0,    1'b0, -1);
        run_session(100,  3,  100,  1'b1, -1);
        run_session(10,   0,  -1,   1'b1, -1);
        run_session(3,    15, -1,   1'b1, -1);
        run_session(20,   3,  20,   1'b0, 4);
        run_session(7,    2,  -1,   1'b1, -1);
        for (int s = 0; s < 15; s++)
            run_session(int'($urandom_range(0, 40)), int'($urandom_range(0, 5)), -1, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/score_round_ctrl.md
SCORE_ROUND_CTRL -- requirements
Module: score_round_ctrl

Interface
REQ-001 Parameter WINDOW, default 2, SHALL be the half-width in counter ticks of the near-hit window; legal range 0..15.
REQ-002 Parameter GAP_CYC, default 4, SHALL be the idle cycles between rounds; legal range 1..255.
REQ-003 i_clk  input  1  SHALL be the single clock; all logic on rising edge.
REQ-004 i_reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 i_start  input  1  SHALL request a new session; sampled only in IDLE.
REQ-006 i_range  input  10  SHALL be the target count; latched on start acceptance.
REQ-007 i_rounds  input  4  SHALL be the number of rounds; latched on start acceptance.
REQ-008 i_hit  input  1  SHALL be the driver action strobe; sampled only in RUN.
REQ-009 o_busy  output  1  SHALL be high in every state except IDLE.
REQ-010 o_window  output  1  SHALL be high in RUN while cnt lies in the scoring window.
REQ-011 o_round  output  4  SHALL be the zero-based index of the current round.
REQ-012 o_score  output  8  SHALL be the accumulated session score.
REQ-013 o_done  output  1  SHALL be a one-cycle pulse at session end.

Function
REQ-014 FSM states SHALL be IDLE, ARM, RUN, GAP and DONE.
REQ-015 IDLE->ARM SHALL occur on i_start=1, latching range_q, rounds_q and round_idx=0, and clearing o_score to 0 (visible in ARM).
REQ-016 i_start with i_rounds=0 SHALL go IDLE->DONE directly, with o_score=0.
REQ-017 ARM SHALL last exactly one cycle, loading the 10-bit cnt with 0, then go to RUN.
REQ-018 In RUN, cnt SHALL increment by 1 per cycle, so cnt=k holds in the (k+1)th RUN cycle (start at T gives cnt=k at T+2+k).
REQ-019 Window bounds SHALL be lo=max(0, range_q-WINDOW) and hi=min(1023, range_q+WINDOW), computed without wrap.
REQ-020 o_window SHALL be combinational: RUN and lo<=cnt<=hi.
REQ-021 The first i_hit in a round SHALL score: +2 if cnt==range_q, +1 if in window but not exact, +0 outside the window.
REQ-022 Every later i_hit in the same round SHALL be ignored, including hits outside the window.
REQ-023 Score updates SHALL be registered, visible on o_score the cycle after the hit.
REQ-024 o_score SHALL NOT overflow, since 15 rounds x 2 = 30 < 256.
REQ-025 RUN SHALL exit to GAP in the cycle after cnt==hi; a hit at cnt==hi SHALL still be evaluated.
REQ-026 GAP SHALL last GAP_CYC cycles.
REQ-027 At the end of GAP, round_idx SHALL increment; if round_idx+1==rounds_q the FSM SHALL go to DONE, else to ARM.
REQ-028 o_round SHALL update on entry to ARM.
REQ-029 DONE SHALL last one cycle with o_done=1 and then return to IDLE.
REQ-030 o_score SHALL hold its final value in IDLE until the next accepted start.
REQ-031 i_start while o_busy=1 SHALL be ignored, and i_range/i_rounds changes while busy SHALL have no effect.
REQ-032 i_hit outside RUN SHALL be ignored, including i_hit coincident with i_start.

Reset
REQ-033 While i_reset=1 at a clock edge, state SHALL become IDLE; cnt, round_idx, gap counter, hit-taken flag and o_score SHALL become 0.
REQ-034 o_busy, o_window, o_done and o_round SHALL read 0 in the cycle after reset.
REQ-035 Reset SHALL take priority over i_start and i_hit in the same cycle, and reset mid-session SHALL abort it without an o_done pulse.

Verification
REQ-036 WINDOW=2, GAP_CYC=4: start at T with range=5, rounds=1, hit at cnt=5 (T+7) -> o_score=2 at T+8; RUN covers T+2..T+9; GAP covers T+10..T+13; o_done=1 at T+14; IDLE at T+15.
REQ-037 range=1, rounds=1, hit at cnt=0 -> lo clamps to 0; o_window high for cnt 0..3; o_score=1.
REQ-038 range=100, rounds=3, hits at cnt=100 then cnt=99 in round 0, cnt=102 in round 1, none in round 2 -> o_score=3 (second hit in round 0 ignored); o_round steps 0,1,2; one o_done.
REQ-039 range=1023, hit at cnt=1021 -> +1; RUN ends after cnt=1023 with no wrap to 0.
REQ-040 start with rounds=0 -> o_done at T+1, o_score=0; i_start pulsed during RUN of a live session -> no effect.
REQ-041 i_reset asserted in RUN of round 1 with o_score=2 -> next cycle all outputs 0; no o_done pulse; a new start is accepted normally.
